mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width of the common memory.
REQ-002 Parameter AW, default 12, memory address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 CPU_REQ  input  1  CPU access request; level, held until CPU_ACK.
REQ-006 CPU_WE  input  1  CPU access type: 1 write, 0 read.
REQ-007 CPU_ADDR  input  AW  CPU address.
REQ-008 CPU_WDATA  input  WIDTH  CPU write data.
REQ-009 IO_REQ, IO_WE, IO_ADDR, IO_WDATA  input  1/1/AW/WIDTH  I/O requester port, same meaning as the CPU port.
REQ-010 CPU_ACK, IO_ACK  output  1 each  one-cycle completion pulse for the granted port.
REQ-011 RDATA  output  WIDTH  read data returned to the requester; valid in the ACK cycle.
REQ-012 BUSY  output  1  high while a transaction is in flight (ACCESS or RESP).
REQ-013 MEM_EN, MEM_WE  output  1 each  memory strobe and write enable.
REQ-014 MEM_ADDR, MEM_WDATA  output  AW/WIDTH  memory address and write data.
REQ-015 MEM_RDATA  input  WIDTH  memory read data, valid the cycle after MEM_EN with MEM_WE=0.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS when CPU_REQ or IO_REQ sampled high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-017 On IDLE->ACCESS the arbiter SHALL latch the winner's WE, ADDR, WDATA and the winner identity; later changes on requester inputs SHALL NOT affect the transaction.
REQ-018 In ACCESS the arbiter SHALL drive MEM_EN=1 for exactly one cycle with the latched MEM_WE, MEM_ADDR, MEM_WDATA; MEM_EN SHALL be 0 in all other states.
REQ-019 In RESP the arbiter SHALL pulse the winner's ACK for one cycle; for reads RDATA SHALL equal MEM_RDATA from that cycle and SHALL hold until the next read completes; writes SHALL leave RDATA unchanged.
REQ-020 Latency SHALL be fixed: REQ sampled at edge N, MEM_EN high in cycle N+1, ACK high in cycle N+2; one transaction every 3 cycles at most.
REQ-021 Only one ACK SHALL be high in any cycle; the loser's REQ SHALL stay pending, unacknowledged, until it wins.
REQ-022 REQ deasserted after being latched SHALL NOT abort the transaction; ACK is still issued.
REQ-023 REQ held high through the ACK cycle SHALL be treated as a new request, sampled in the following IDLE cycle.
REQ-024 BUSY SHALL be 1 in ACCESS and RESP, 0 in IDLE.
REQ-025 A 1-bit LAST register SHALL record the most recent winner (0 CPU, 1 IO), updated on IDLE->ACCESS.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, LAST=1, all ACKs 0, MEM_EN 0, MEM_WE 0, MEM_ADDR 0, MEM_WDATA 0, RDATA 0, BUSY 0.
REQ-027 Reset mid-transaction SHALL abandon it with no ACK issued; first arbitration SHALL occur on the first rising edge with rst_n=1.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests the port not equal to LAST SHALL win (after reset CPU wins first).
REQ-029 Macro ARB_ROUND_ROBIN_EN undefined: CPU SHALL always win simultaneous requests (fixed priority); LAST still maintained but unused for arbitration.

Verification
REQ-030 CPU read only, CPU_ADDR=12'h010, memory holds 16'hBEEF -> MEM_EN with MEM_ADDR=12'h010 at N+1, CPU_ACK and RDATA=16'hBEEF at N+2, IO_ACK never high.
REQ-031 IO write IO_ADDR=12'h0FF, IO_WDATA=16'h1234 -> MEM_EN=MEM_WE=1 at N+1 with those values, IO_ACK at N+2, RDATA unchanged.
REQ-032 Both request continuously for 4 transactions, macro defined -> grant order CPU, IO, CPU, IO, ACKs 3 cycles apart; macro undefined -> CPU, CPU, CPU, CPU.
REQ-033 CPU_REQ dropped in cycle N+1 after being latched -> transaction completes, CPU_ACK at N+2.
REQ-034 rst_n pulsed low during ACCESS -> no ACK, MEM_EN 0 immediately, BUSY 0; pending request serviced after release with ACK 2 cycles after first sample.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports, the response signals and
// the memory-side strobes of the memory arbiter.
//   Requester side : CPU_REQ/WE/ADDR/WDATA, IO_REQ/WE/ADDR/WDATA in,
//                    CPU_ACK, IO_ACK, RDATA, BUSY out.
//   Memory side    : MEM_EN/WE/ADDR/WDATA out, MEM_RDATA in.
// Modports: slave  = the arbiter itself,
//           master = the environment (requesters + memory) driving it.
interface mem_arbiter_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 12
);
    logic             CPU_REQ;
    logic             CPU_WE;
    logic [AW-1:0]    CPU_ADDR;
    logic [WIDTH-1:0] CPU_WDATA;

    logic             IO_REQ;
    logic             IO_WE;
    logic [AW-1:0]    IO_ADDR;
    logic [WIDTH-1:0] IO_WDATA;

    logic             CPU_ACK;
    logic             IO_ACK;
    logic [WIDTH-1:0] RDATA;
    logic             BUSY;

    logic             MEM_EN;
    logic             MEM_WE;
    logic [AW-1:0]    MEM_ADDR;
    logic [WIDTH-1:0] MEM_WDATA;
    logic [WIDTH-1:0] MEM_RDATA;

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
        input  IO_REQ, IO_WE, IO_ADDR, IO_WDATA,
        input  MEM_RDATA,
        output CPU_ACK, IO_ACK, RDATA, BUSY,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
        output IO_REQ, IO_WE, IO_ADDR, IO_WDATA,
        output MEM_RDATA,
        input  CPU_ACK, IO_ACK, RDATA, BUSY,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / IO) arbiter in front of a single synchronous
// memory. Fixed 3-cycle transaction: IDLE (arbitrate + latch) -> ACCESS
// (one MEM_EN strobe) -> RESP (one ACK pulse, read data returned).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave (requester ports, ACKs, RDATA, BUSY,
//           memory strobes and MEM_RDATA)
// Configuration:
//   ARB_ROUND_ROBIN_EN defined   - simultaneous requests go to the port that
//                                  did not win last (CPU first after reset).
//   ARB_ROUND_ROBIN_EN undefined - CPU always wins simultaneous requests.
// RDATA is the one output not taken straight from a flop: in the ACK cycle of
// a read it forwards MEM_RDATA (memory data is only valid in that cycle),
// otherwise it shows the held value of the last completed read.
module mem_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Latched request payload of the current winner
    typedef struct packed {
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
    } xact_t;

    state_e           state_q, state_d;
    xact_t            xact_q, xact_d;
    xact_t            cpu_xact_c, io_xact_c;
    logic             last_q, last_d;
    logic             grant_c, win_io_c, rd_resp_c;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic             cpu_ack_q, cpu_ack_d;
    logic             io_ack_q, io_ack_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Requester payloads in latch format
    assign cpu_xact_c = '{we: bus.CPU_WE, addr: bus.CPU_ADDR, wdata: bus.CPU_WDATA};
    assign io_xact_c  = '{we: bus.IO_WE,  addr: bus.IO_ADDR,  wdata: bus.IO_WDATA};

    // A grant happens on any request seen while idle
    assign grant_c = (state_q == IDLE) && (bus.CPU_REQ || bus.IO_REQ);

    // Arbitration: IO wins alone, or on a tie when it was not the last winner
`ifdef ARB_ROUND_ROBIN_EN
    assign win_io_c = bus.IO_REQ && (!bus.CPU_REQ || !last_q);
`else
    assign win_io_c = bus.IO_REQ && !bus.CPU_REQ;
`endif

    // Read completion cycle: memory data is valid now
    assign rd_resp_c = (state_q == RESP) && !xact_q.we;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_c) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values, all taken from the upcoming state so the
    // flops line up with the state they belong to
    always_comb begin
        xact_d    = xact_q;
        last_d    = last_q;
        rdata_d   = rdata_q;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        cpu_ack_d = 1'b0;
        io_ack_d  = 1'b0;
        busy_d    = 1'b0;

        if (grant_c) begin
            xact_d = win_io_c ? io_xact_c : cpu_xact_c;
            last_d = win_io_c;
        end

        if (rd_resp_c) begin
            rdata_d = bus.MEM_RDATA;
        end

        mem_en_d  = (state_d == ACCESS);
        mem_we_d  = (state_d == ACCESS) && xact_d.we;
        // last_q already names the winner once the grant has been taken
        cpu_ack_d = (state_d == RESP) && !last_q;
        io_ack_d  = (state_d == RESP) && last_q;
        busy_d    = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xact_q    <= '0;
            last_q    <= 1'b1;
            rdata_q   <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            io_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            xact_q    <= xact_d;
            last_q    <= last_d;
            rdata_q   <= rdata_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            cpu_ack_q <= cpu_ack_d;
            io_ack_q  <= io_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.MEM_EN    = mem_en_q;
    assign bus.MEM_WE    = mem_we_q;
    assign bus.MEM_ADDR  = xact_q.addr;
    assign bus.MEM_WDATA = xact_q.wdata;
    assign bus.CPU_ACK   = cpu_ack_q;
    assign bus.IO_ACK    = io_ack_q;
    assign bus.BUSY      = busy_q;
    // Forward read data in its completion cycle, hold it afterwards
    assign bus.RDATA     = rd_resp_c ? bus.MEM_RDATA : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter, checked
// every cycle against a transaction-level model plus literal spot checks.
module tb_mem_arbiter;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 12;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    mem_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous memory: read data valid the cycle after the strobe,
    // random junk whenever it is not valid
    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.MEM_EN && !bus.MEM_WE) bus.MEM_RDATA <= mem[bus.MEM_ADDR];
        else                           bus.MEM_RDATA <= WIDTH'($urandom);
        if (bus.MEM_EN && bus.MEM_WE)  mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
    end

    // Transaction-level model: a request seen at an eligible edge k becomes a
    // transaction with its strobe after edge k, its ACK after edge k+1, and
    // the next eligible edge is k+3.
    int               k         = 0;
    int               g_edge    = -10;
    int               free_edge = 0;
    bit               g_io, g_we;
    logic [AW-1:0]    g_addr;
    logic [WIDTH-1:0] g_wdata;
    logic [WIDTH-1:0] hold_rd   = '0;
    bit               last_w    = 1'b1;

    always @(posedge clk) begin
        bit               e_en, e_ack;
        logic [WIDTH-1:0] e_rd;
        k++;
        if (!rst_n) begin
            g_edge    = -10;
            free_edge = k + 1;
            last_w    = 1'b1;
            hold_rd   = '0;
        end else if (k >= free_edge && (bus.CPU_REQ || bus.IO_REQ)) begin
            g_io      = bus.IO_REQ && (!bus.CPU_REQ || (RR && !last_w));
            g_we      = g_io ? bus.IO_WE : bus.CPU_WE;
            g_addr    = g_io ? bus.IO_ADDR : bus.CPU_ADDR;
            g_wdata   = g_io ? bus.IO_WDATA : bus.CPU_WDATA;
            last_w    = g_io;
            g_edge    = k;
            free_edge = k + 3;
        end
        #1;
        e_en  = (g_edge == k);
        e_ack = (g_edge == k - 1);
        e_rd  = hold_rd;
        if (e_ack && !g_we) begin
            e_rd    = mem[g_addr];
            hold_rd = e_rd;
        end
        chk("mem_en",  32'(bus.MEM_EN),  32'(e_en));
        chk("cpu_ack", 32'(bus.CPU_ACK), 32'(e_ack && !g_io));
        chk("io_ack",  32'(bus.IO_ACK),  32'(e_ack && g_io));
        chk("busy",    32'(bus.BUSY),    32'(e_en || e_ack));
        chk("rdata",   32'(bus.RDATA),   32'(e_rd));
        if (e_en) begin
            chk("mem_we",    32'(bus.MEM_WE),    32'(g_we));
            chk("mem_addr",  32'(bus.MEM_ADDR),  32'(g_addr));
            chk("mem_wdata", 32'(bus.MEM_WDATA), 32'(g_wdata));
        end
    end

    task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus.CPU_REQ = req; bus.CPU_WE = we; bus.CPU_ADDR = a; bus.CPU_WDATA = d;
    endtask

    task automatic set_io(input bit req, input bit we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus.IO_REQ = req; bus.IO_WE = we; bus.IO_ADDR = a; bus.IO_WDATA = d;
    endtask

    task automatic rnd_port(input bit io, input bit req);
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        bit               we;
        a  = AW'($urandom % 32);
        d  = WIDTH'($urandom);
        we = 1'($urandom % 2);
        if (io) set_io(req, we, a, d);
        else    set_cpu(req, we, a, d);
    endtask

    initial begin
        logic [WIDTH-1:0] exp_rd;
        bit               e_c, e_i;
        set_cpu(1'b0, 1'b0, '0, '0);
        set_io(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < (1 << AW); i++) mem[i] = WIDTH'($urandom);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_mem_en",    32'(bus.MEM_EN),    32'd0);
        chk("rst_mem_we",    32'(bus.MEM_WE),    32'd0);
        chk("rst_mem_addr",  32'(bus.MEM_ADDR),  32'd0);
        chk("rst_mem_wdata", 32'(bus.MEM_WDATA), 32'd0);
        chk("rst_rdata",     32'(bus.RDATA),     32'd0);
        chk("rst_busy",      32'(bus.BUSY),      32'd0);
        chk("rst_acks",      32'({bus.CPU_ACK, bus.IO_ACK}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU read of 0x010 holding 0xBEEF
        mem[12'h010] = 16'hBEEF;
        set_cpu(1'b1, 1'b0, 12'h010, 16'h0000);
        @(negedge clk);
        chk("rd_en",   32'(bus.MEM_EN),   32'd1);
        chk("rd_addr", 32'(bus.MEM_ADDR), 32'h010);
        @(negedge clk);
        chk("rd_ack",   32'(bus.CPU_ACK), 32'd1);
        chk("rd_ioack", 32'(bus.IO_ACK),  32'd0);
        chk("rd_data",  32'(bus.RDATA),   32'hBEEF);
        set_cpu(1'b0, 1'b0, 12'h010, 16'h0000);
        @(negedge clk);

        // IO write 0x1234 to 0x0FF, RDATA must keep 0xBEEF
        set_io(1'b1, 1'b1, 12'h0FF, 16'h1234);
        @(negedge clk);
        chk("wr_en",    32'(bus.MEM_EN),    32'd1);
        chk("wr_we",    32'(bus.MEM_WE),    32'd1);
        chk("wr_addr",  32'(bus.MEM_ADDR),  32'h0FF);
        chk("wr_wdata", 32'(bus.MEM_WDATA), 32'h1234);
        @(negedge clk);
        chk("wr_ack",   32'(bus.IO_ACK),  32'd1);
        chk("wr_cack",  32'(bus.CPU_ACK), 32'd0);
        chk("wr_rdata", 32'(bus.RDATA),   32'hBEEF);
        set_io(1'b0, 1'b0, 12'h0FF, 16'h1234);
        @(negedge clk);

        // CPU request withdrawn (and payload changed) after being latched
        exp_rd = mem[12'h123];
        set_cpu(1'b1, 1'b0, 12'h123, 16'h0000);
        @(negedge clk);
        chk("drop_en", 32'(bus.MEM_EN), 32'd1);
        set_cpu(1'b0, 1'b1, 12'h3A5, 16'h5555);
        @(negedge clk);
        chk("drop_ack",   32'(bus.CPU_ACK), 32'd1);
        chk("drop_rdata", 32'(bus.RDATA),   32'(exp_rd));
        @(negedge clk);

        // Both ports requesting continuously from reset: grant order
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_cpu(1'b1, 1'b0, 12'h001, 16'h0000);
        set_io(1'b1, 1'b0, 12'h002, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            e_c = (i % 3 == 1) && (!RR || ((i / 3) % 2 == 0));
            e_i = (i % 3 == 1) && RR && ((i / 3) % 2 == 1);
            chk("both_cack", 32'(bus.CPU_ACK), 32'(e_c));
            chk("both_iack", 32'(bus.IO_ACK),  32'(e_i));
        end
        set_cpu(1'b0, 1'b0, '0, '0);
        set_io(1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);

        // Reset during ACCESS, request kept pending through reset
        set_cpu(1'b1, 1'b0, 12'h020, 16'h0000);
        @(negedge clk);
        chk("mid_en", 32'(bus.MEM_EN), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en",   32'(bus.MEM_EN),  32'd0);
        chk("mid_rst_busy", 32'(bus.BUSY),    32'd0);
        chk("mid_rst_ack",  32'(bus.CPU_ACK), 32'd0);
        @(negedge clk);
        chk("mid_noack", 32'(bus.CPU_ACK), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_en",   32'(bus.MEM_EN),  32'd1);
        chk("post_ack0", 32'(bus.CPU_ACK), 32'd0);
        @(negedge clk);
        chk("post_ack", 32'(bus.CPU_ACK), 32'd1);
        set_cpu(1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom % 500 == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                bit io, req, ack;
                io  = (p == 1);
                req = io ? bus.IO_REQ : bus.CPU_REQ;
                ack = io ? bus.IO_ACK : bus.CPU_ACK;
                if (!req) begin
                    if ($urandom % 3 == 0) rnd_port(io, 1'b1);
                end else if (ack) begin
                    rnd_port(io, ($urandom % 4 == 0));
                end else if ($urandom % 8 == 0) begin
                    rnd_port(io, 1'b0);
                end else if ($urandom % 6 == 0) begin
                    rnd_port(io, 1'b1);
                end
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
